// File: rtl/player_pkg.sv
// Shared types, tile codes and tile-index helper for the player controller.
package player_pkg;

  localparam logic [3:0] TILE_EMPTY = 4'd0;
  localparam logic [3:0] TILE_BRICK = 4'd1;
  localparam logic [3:0] TILE_WALL  = 4'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_CHK,
    S_DEAD,
    S_OVER
  } state_e;

  // Map tile index of a pixel: row * map_w + column, 10-bit wrap-free for legal maps.
  function automatic logic [9:0] tile_idx(input logic [9:0] x, input logic [9:0] y,
                                          input int unsigned tile_log2,
                                          input int unsigned map_w);
    logic [9:0] tx;
    logic [9:0] ty;
    tx = x >> tile_log2;
    ty = y >> tile_log2;
    return ty * 10'(map_w) + tx;
  endfunction

endpackage

// File: rtl/player_ctrl_if.sv
// Bus between the player controller and its keyboard, map RAM, danger and render neighbours.
interface player_ctrl_if #(
  parameter int unsigned N_DANGER = 10,
  parameter int unsigned LIVES    = 3
);
  localparam int unsigned LW = $clog2(LIVES + 1);

  logic                     enable;
  logic [7:0]               keycode;
  logic [N_DANGER-1:0][9:0] danger_addr;
  logic [N_DANGER-1:0]      danger_valid;
  logic [3:0][9:0]          tile_addr;  // TL, TR, BL, BR
  logic [3:0][3:0]          tile_data;
  logic [9:0]               userX;
  logic [9:0]               userY;
  logic                     bomb_drop;
  logic                     collide;
  logic [LW-1:0]            lives_left;
  logic                     invuln;
  logic                     game_over;

  modport master (
    output enable, keycode, danger_addr, danger_valid, tile_data,
    input  tile_addr, userX, userY, bomb_drop, collide, lives_left, invuln, game_over
  );

  modport slave (
    input  enable, keycode, danger_addr, danger_valid, tile_data,
    output tile_addr, userX, userY, bomb_drop, collide, lives_left, invuln, game_over
  );
endinterface

// File: rtl/danger_match.sv
// Combinational check of four corner tiles against a list of valid explosion tiles.
module danger_match #(
  parameter int unsigned N_DANGER = 10
) (
  input  logic [3:0][9:0]          corner_i,
  input  logic [N_DANGER-1:0][9:0] addr_i,
  input  logic [N_DANGER-1:0]      valid_i,
  output logic                     hit_o
);

  // Any valid entry equal to any corner is a hit.
  always_comb begin
    hit_o = 1'b0;
    for (int i = 0; i < N_DANGER; i++) begin
      for (int c = 0; c < 4; c++) begin
        if (valid_i[i] && (addr_i[i] == corner_i[c])) hit_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/player_ctrl.sv
// Per-player movement, tile collision, life counting and bomb-drop controller.
module player_ctrl
  import player_pkg::*;
#(
  parameter logic [7:0]  KEY_L         = 8'h04,
  parameter logic [7:0]  KEY_R         = 8'h07,
  parameter logic [7:0]  KEY_D         = 8'h16,
  parameter logic [7:0]  KEY_U         = 8'h1A,
  parameter logic [7:0]  KEY_B         = 8'h19,
  parameter int unsigned TILE_LOG2     = 5,
  parameter int unsigned MAP_W         = 20,
  parameter int unsigned X_MIN         = 32,
  parameter int unsigned X_MAX         = 575,
  parameter int unsigned Y_MIN         = 32,
  parameter int unsigned Y_MAX         = 447,
  parameter int unsigned SPR_W         = 20,
  parameter int unsigned SPR_H         = 27,
  parameter int unsigned STEP          = 1,
  parameter int unsigned SPAWN_X       = 39,
  parameter int unsigned SPAWN_Y       = 35,
  parameter int unsigned N_DANGER      = 10,
  parameter int unsigned LIVES         = 3,
  parameter int unsigned INVULN_FRAMES = 64
) (
  input logic          frame_clk,
  input logic          Reset,
  player_ctrl_if.slave bus
);

  localparam int unsigned LW = $clog2(LIVES + 1);
  localparam int unsigned IW = $clog2(INVULN_FRAMES + 1);

  localparam logic [9:0]    XMin   = 10'(X_MIN);
  localparam logic [9:0]    XMax   = 10'(X_MAX);
  localparam logic [9:0]    YMin   = 10'(Y_MIN);
  localparam logic [9:0]    YMax   = 10'(Y_MAX);
  localparam logic [9:0]    SprW   = 10'(SPR_W);
  localparam logic [9:0]    SprH   = 10'(SPR_H);
  localparam logic [9:0]    Step   = 10'(STEP);
  localparam logic [9:0]    SpawnX = 10'(SPAWN_X);
  localparam logic [9:0]    SpawnY = 10'(SPAWN_Y);
  localparam logic [LW-1:0] Lives0 = LW'(LIVES);
  localparam logic [IW-1:0] InvN   = IW'(INVULN_FRAMES);

  state_e          state_q, state_d;
  logic [9:0]      pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [9:0]      cand_x_q, cand_x_d, cand_y_q, cand_y_d;
  logic [LW-1:0]   lives_q, lives_d;
  logic [IW-1:0]   inv_cnt_q, inv_cnt_d;
  logic [7:0]      prev_key_q, prev_key_d;
  logic            bomb_q, bomb_d, collide_q, collide_d;
  logic [3:0][9:0] cand_tiles, pos_tiles;
  logic            hit, blocked, active;

  // Corner tiles of the candidate box (to RAM) and of the committed box (danger check).
  always_comb begin
    cand_tiles[0] = tile_idx(cand_x_q,        cand_y_q,        TILE_LOG2, MAP_W);
    cand_tiles[1] = tile_idx(cand_x_q + SprW, cand_y_q,        TILE_LOG2, MAP_W);
    cand_tiles[2] = tile_idx(cand_x_q,        cand_y_q + SprH, TILE_LOG2, MAP_W);
    cand_tiles[3] = tile_idx(cand_x_q + SprW, cand_y_q + SprH, TILE_LOG2, MAP_W);
    pos_tiles[0]  = tile_idx(pos_x_q,         pos_y_q,         TILE_LOG2, MAP_W);
    pos_tiles[1]  = tile_idx(pos_x_q + SprW,  pos_y_q,         TILE_LOG2, MAP_W);
    pos_tiles[2]  = tile_idx(pos_x_q,         pos_y_q + SprH,  TILE_LOG2, MAP_W);
    pos_tiles[3]  = tile_idx(pos_x_q + SprW,  pos_y_q + SprH,  TILE_LOG2, MAP_W);
  end

  danger_match #(.N_DANGER(N_DANGER)) u_danger (
    .corner_i (pos_tiles),
    .addr_i   (bus.danger_addr),
    .valid_i  (bus.danger_valid),
    .hit_o    (hit)
  );

  // Any solid corner tile blocks the pending move.
  always_comb begin
    blocked = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if ((bus.tile_data[c] == TILE_BRICK) || (bus.tile_data[c] == TILE_WALL)) blocked = 1'b1;
    end
  end

  assign active = (state_q == S_IDLE) || (state_q == S_WAIT) || (state_q == S_CHK);

  // Next-state: move proposal/check pipeline, death/respawn, bomb edge detect.
  always_comb begin
    state_d    = state_q;
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    cand_x_d   = cand_x_q;
    cand_y_d   = cand_y_q;
    lives_d    = lives_q;
    inv_cnt_d  = inv_cnt_q;
    prev_key_d = prev_key_q;
    bomb_d     = 1'b0;
    collide_d  = 1'b0;
    if (bus.enable) begin
      prev_key_d = bus.keycode;
      if (inv_cnt_q != '0) inv_cnt_d = inv_cnt_q - 1'b1;
      bomb_d = active && (bus.keycode == KEY_B) && (prev_key_q != KEY_B);
      unique case (state_q)
        S_IDLE: begin
          // Bound checks are written to avoid 10-bit wrap on left/up.
          if (bus.keycode == KEY_L) begin
            if (pos_x_q >= XMin + Step) begin
              cand_x_d = pos_x_q - Step;
              cand_y_d = pos_y_q;
              state_d  = S_WAIT;
            end
          end else if (bus.keycode == KEY_R) begin
            if (pos_x_q + Step + SprW <= XMax) begin
              cand_x_d = pos_x_q + Step;
              cand_y_d = pos_y_q;
              state_d  = S_WAIT;
            end
          end else if (bus.keycode == KEY_U) begin
            if (pos_y_q >= YMin + Step) begin
              cand_x_d = pos_x_q;
              cand_y_d = pos_y_q - Step;
              state_d  = S_WAIT;
            end
          end else if (bus.keycode == KEY_D) begin
            if (pos_y_q + Step + SprH <= YMax) begin
              cand_x_d = pos_x_q;
              cand_y_d = pos_y_q + Step;
              state_d  = S_WAIT;
            end
          end
        end
        S_WAIT: state_d = S_CHK;
        S_CHK: begin
          if (!blocked) begin
            pos_x_d = cand_x_q;
            pos_y_d = cand_y_q;
          end
          state_d = S_IDLE;
        end
        S_DEAD: begin
          if (lives_q == '0) begin
            state_d = S_OVER;
          end else begin
            pos_x_d   = SpawnX;
            pos_y_d   = SpawnY;
            cand_x_d  = SpawnX;
            cand_y_d  = SpawnY;
            inv_cnt_d = InvN;
            state_d   = S_IDLE;
          end
        end
        S_OVER:  state_d = S_OVER;
        default: state_d = S_IDLE;
      endcase
      // Lethal hit overrides any commit decided above.
      if (active && hit && (inv_cnt_q == '0)) begin
        collide_d = 1'b1;
        lives_d   = lives_q - 1'b1;
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        state_d   = S_DEAD;
      end
    end
  end

  // State registers with asynchronous active-high reset to spawn.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      pos_x_q    <= SpawnX;
      pos_y_q    <= SpawnY;
      cand_x_q   <= SpawnX;
      cand_y_q   <= SpawnY;
      lives_q    <= Lives0;
      inv_cnt_q  <= '0;
      prev_key_q <= 8'h00;
      bomb_q     <= 1'b0;
      collide_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_x_q    <= pos_x_d;
      pos_y_q    <= pos_y_d;
      cand_x_q   <= cand_x_d;
      cand_y_q   <= cand_y_d;
      lives_q    <= lives_d;
      inv_cnt_q  <= inv_cnt_d;
      prev_key_q <= prev_key_d;
      bomb_q     <= bomb_d;
      collide_q  <= collide_d;
    end
  end

  assign bus.tile_addr  = cand_tiles;
  assign bus.userX      = pos_x_q;
  assign bus.userY      = pos_y_q;
  assign bus.lives_left = lives_q;
  assign bus.invuln     = (inv_cnt_q != '0);
  assign bus.game_over  = (state_q == S_OVER);
  // Pulses are suppressed whenever the block is frozen.
  assign bus.bomb_drop  = bomb_q & bus.enable;
  assign bus.collide    = collide_q & bus.enable;

endmodule

// File: tb/tb_player_ctrl.sv
// Self-checking bench for player_ctrl: vector table, move scoreboard, corner sequences.
module tb_player_ctrl;
  import player_pkg::*;

  localparam logic [7:0] KL = 8'h04, KR = 8'h07, KD = 8'h16, KU = 8'h1A, KB = 8'h19;

  logic frame_clk = 1'b0;
  logic Reset     = 1'b1;
  always #5 frame_clk = ~frame_clk;

  player_ctrl_if #(.N_DANGER(10), .LIVES(3)) bus ();

  player_ctrl dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .bus       (bus)
  );

  // Map RAM model: data for tile_addr appears one clock later.
  logic [3:0] map_mem [0:1023];
  always @(posedge frame_clk) begin
    for (int c = 0; c < 4; c++) bus.tile_data[c] <= map_mem[bus.tile_addr[c]];
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge frame_clk);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    bus.enable       = 1'b1;
    bus.keycode      = 8'h00;
    bus.danger_addr  = '0;
    bus.danger_valid = '0;
    tick(2);
    Reset = 1'b0;
  endtask

  task automatic wait_collide(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      tick(1);
      if (bus.collide === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic count_bomb(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      tick(1);
      if (bus.bomb_drop === 1'b1) cnt++;
    end
  endtask

  typedef struct {
    logic [7:0] key;
    int         ex;
    int         ey;
  } vec_t;

  typedef struct {
    int cyc;
    int x;
  } sb_t;

  vec_t vecs [6];
  sb_t  sbq [$];
  sb_t  e;
  int   prev, n, cnt, bad;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) map_mem[i] = TILE_EMPTY;
    vecs[0] = '{KL,    38, 35};
    vecs[1] = '{KR,    40, 35};
    vecs[2] = '{KU,    39, 34};
    vecs[3] = '{KD,    39, 36};
    vecs[4] = '{8'h00, 39, 35};
    vecs[5] = '{KB,    39, 35};

    // Reset state.
    do_reset();
    check("rst_x", bus.userX, 39);
    check("rst_y", bus.userY, 35);
    check("rst_lives", bus.lives_left, 3);
    check("rst_invuln", bus.invuln, 0);
    check("rst_over", bus.game_over, 0);
    check("rst_bomb", bus.bomb_drop, 0);
    check("rst_collide", bus.collide, 0);
    check("rst_tile_tl", bus.tile_addr[0], 21);
    check("rst_tile_br", bus.tile_addr[3], 21);

    // Single key sample: no update after 2 clocks, committed after 3.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      bus.keycode = vecs[i].key;
      tick(1);
      bus.keycode = 8'h00;
      tick(1);
      check($sformatf("vec%0d_early_x", i), bus.userX, 39);
      tick(1);
      check($sformatf("vec%0d_x", i), bus.userX, vecs[i].ex);
      check($sformatf("vec%0d_y", i), bus.userY, vecs[i].ey);
    end

    // Held right key into a wall at tile 22: scoreboard of committed positions.
    do_reset();
    map_mem[22] = TILE_WALL;
    bus.keycode = KR;
    for (int k = 0; k < 4; k++) sbq.push_back('{3 * (k + 1), 40 + k});
    prev = 39;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      tick(1);
      if (int'(bus.userX) != prev) begin
        if (sbq.size() == 0) begin
          check("sb_extra_move", bus.userX, prev);
        end else begin
          e = sbq.pop_front();
          check("sb_x", bus.userX, e.x);
          check("sb_cycle", cyc, e.cyc);
        end
        prev = int'(bus.userX);
      end
    end
    check("sb_drained", sbq.size(), 0);
    check("wall_x", bus.userX, 43);
    check("wall_y", bus.userY, 35);
    map_mem[22] = TILE_EMPTY;

    // Left edge: stop at X_MIN without proposing an out-of-range candidate.
    do_reset();
    bus.keycode = KL;
    tick(21);
    check("xmin_reach", bus.userX, 32);
    bad = 0;
    for (int i = 0; i < 9; i++) begin
      tick(1);
      if (bus.tile_addr[0] !== 10'd21) bad++;
    end
    check("xmin_no_wait", bad, 0);
    check("xmin_hold", bus.userX, 32);

    // Lethal hits with respawn invulnerability until game over.
    do_reset();
    bus.danger_addr[3]  = 10'd21;
    bus.danger_valid[3] = 1'b1;
    for (int h = 0; h < 3; h++) begin
      wait_collide(5, n);
      check($sformatf("hit%0d_latency", h), n, 1);
      check($sformatf("hit%0d_lives", h), bus.lives_left, 2 - h);
      tick(1);
      check($sformatf("hit%0d_pulse_end", h), bus.collide, 0);
      if (h < 2) begin
        check($sformatf("hit%0d_respawn_x", h), bus.userX, 39);
        check($sformatf("hit%0d_respawn_y", h), bus.userY, 35);
        cnt = 0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
          if (bus.invuln !== 1'b1) break;
          cnt++;
          if (bus.collide === 1'b1) bad++;
          tick(1);
        end
        check($sformatf("hit%0d_invuln_len", h), cnt, 64);
        check($sformatf("hit%0d_no_rehit", h), bad, 0);
      end else begin
        check("over_set", bus.game_over, 1);
      end
    end
    bus.keycode = KL;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (bus.collide === 1'b1 || bus.game_over !== 1'b1) bad++;
    end
    check("over_sticky", bad, 0);
    check("over_no_move", bus.userX, 39);
    check("over_lives", bus.lives_left, 0);
    Reset = 1'b1;
    #1;
    check("over_rst_lives", bus.lives_left, 3);
    check("over_rst_flag", bus.game_over, 0);

    // Bomb edge detection, including disabled spans.
    do_reset();
    bus.keycode = KB;
    count_bomb(10, cnt);
    check("bomb_held", cnt, 1);
    bus.keycode = 8'h00;
    count_bomb(2, cnt);
    check("bomb_release", cnt, 0);
    bus.keycode = KB;
    count_bomb(3, cnt);
    check("bomb_repress", cnt, 1);
    bus.keycode = 8'h00;
    count_bomb(2, cnt);
    bus.enable  = 1'b0;
    bus.keycode = KB;
    count_bomb(5, cnt);
    check("bomb_disabled", cnt, 0);
    bus.keycode = 8'h00;
    count_bomb(1, cnt);
    bus.enable  = 1'b1;
    bus.keycode = KB;
    count_bomb(2, cnt);
    check("bomb_after_enable", cnt, 1);
    bus.enable  = 1'b0;
    bus.keycode = 8'h00;
    count_bomb(2, cnt);
    bus.keycode = KB;
    count_bomb(2, cnt);
    bus.enable = 1'b1;
    count_bomb(3, cnt);
    check("bomb_held_prev", cnt, 0);
    bus.enable  = 1'b0;
    bus.keycode = KR;
    tick(10);
    check("freeze_x", bus.userX, 39);
    bus.enable = 1'b1;

    // Async reset while a move is waiting on the RAM.
    do_reset();
    bus.keycode = KR;
    tick(1);
    bus.keycode = 8'h00;
    #2;
    Reset = 1'b1;
    #1;
    check("arst_x", bus.userX, 39);
    check("arst_cand_tr", bus.tile_addr[1], 21);
    tick(1);
    Reset = 1'b0;
    tick(5);
    check("arst_no_commit", bus.userX, 39);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/player_ctrl.md
Name: player_ctrl

Overview:
Parametrised per-player movement/life controller, next generation of the single-player user controller. It does the following:
- Turns keyboard scancodes into tile-checked moves of a sprite bounding box.
- Checks the four box corners against an external dual-port map RAM through a proposal/check pipeline.
- Detects explosion tiles, counts lives with a respawn invulnerability window, and emits bomb-drop pulses.

One instance per player; sits between the keycode decoder and the renderer/bomb logic.

Parameters:
- KEY_L, 8'h04, scancode for left
- KEY_R, 8'h07, scancode for right
- KEY_D, 8'h16, scancode for down
- KEY_U, 8'h1A, scancode for up
- KEY_B, 8'h19, scancode for bomb
- TILE_LOG2, 5, log2 of tile pixel size
- MAP_W, 20, tiles per map row
- X_MIN / X_MAX, 32 / 575, legal pixel range for the box left / right edge
- Y_MIN / Y_MAX, 32 / 447, legal pixel range for the box top / bottom edge
- SPR_W / SPR_H, 20 / 27, box width / height offset in pixels
- STEP, 1, pixels per accepted move
- SPAWN_X / SPAWN_Y, 39 / 35, respawn position
- N_DANGER, 10, number of explosion-tile address inputs
- LIVES, 3, initial lives
- INVULN_FRAMES, 64, frames of invulnerability after respawn

Ports:
- frame_clk  in  1  frame clock
- Reset  in  1  asynchronous, active-high
- enable  in  1  game running; low freezes the block
- keycode  in  8  current scancode
- danger_addr  in  N_DANGER x 10  explosion tile indices
- danger_valid  in  N_DANGER  per-entry valid
- tile_addr  out  4 x 10  corner tile indices of the candidate box, order TL, TR, BL, BR
- tile_data  in  4 x 4  map RAM q for tile_addr, registered one frame_clk later
- userX / userY  out  10  committed box top-left position
- bomb_drop  out  1  one-cycle pulse
- collide  out  1  one-cycle pulse on life loss
- lives_left  out  $clog2(LIVES+1)  remaining lives
- invuln  out  1  invulnerability window active
- game_over  out  1  sticky once lives reach 0

Behaviour:
Reset (async) sets:
- userX = SPAWN_X, userY = SPAWN_Y, candidate = spawn.
- lives_left = LIVES.
- bomb_drop, collide, invuln, game_over = 0.
- state = S_IDLE, invuln counter = 0.

Tile index: tile(x, y) = (y >> TILE_LOG2) * MAP_W + (x >> TILE_LOG2).
- Corners are (x, y), (x+SPR_W, y), (x, y+SPR_H), (x+SPR_W, y+SPR_H).
- tile_addr is always derived from the candidate registers.

States:
- S_IDLE: direction key held → candidate = pos ± STEP on one axis; go S_WAIT.
  - Priority L > R > U > D.
  - If the candidate edge falls outside [X_MIN, X_MAX] or [Y_MIN, Y_MAX], it is dropped and the state stays S_IDLE.
  - No key → stay.
- S_WAIT: one cycle for the RAM to sample tile_addr; go S_CHK.
- S_CHK: if any tile_data == TILE_BRICK or TILE_WALL, reject (position unchanged). Otherwise commit candidate to userX/userY. Go S_IDLE.
  - Accepted move latency: 3 frame_clk from key sample to the userX/userY update.
- S_DEAD: entered on lethal hit.
  - Next cycle: position = spawn, candidate = spawn, invuln counter = INVULN_FRAMES; go S_IDLE.
  - If lives_left == 0 after the decrement, go S_OVER instead.
- S_OVER: terminal until Reset. game_over = 1; keys ignored; no pulses.

Danger check:
- Every cycle in S_IDLE/S_WAIT/S_CHK, all four corners of the committed position are compared against every valid danger_addr.
- A match with invuln == 0 gives a lethal hit:
  - collide pulses 1 cycle and lives_left decrements;
  - the pending move is discarded and the state goes to S_DEAD.
- Lethal hit has priority over a commit in the same cycle.

Invulnerability:
- invuln = (counter != 0).
- The counter decrements once per cycle while enable = 1.
- Danger matches are ignored while invuln = 1.

bomb_drop:
- Pulses on the rising edge of (keycode == KEY_B), i.e. when the previous cycle's keycode != KEY_B.
- Only in non-DEAD/OVER states; holding the key gives one pulse.
- Independent of movement (bomb plus pending move both proceed).

enable = 0:
- All state, counters and the previous-key register hold; pulses are forced 0.
- Resuming continues from the held state. A key edge across a disabled span is evaluated against the held previous key.

Arithmetic:
- 10-bit unsigned throughout.
- Left/up candidate with pos < STEP + X_MIN / Y_MIN is rejected by the bound check; no wrap is permitted.

Decomposition:
Package player_pkg holds:
- tile codes TILE_EMPTY = 0, TILE_BRICK = 1, TILE_WALL = 2;
- the state enum {S_IDLE, S_WAIT, S_CHK, S_DEAD, S_OVER};
- function tile_idx(x, y).

Sub-module danger_match: combinational, 4 corner indices vs N_DANGER addresses/valids → 1-bit hit. Reused by bomb logic.

Test Plan:
- Reset, enable = 1, keycode = 8'h07 held, tile_data all 0 → userX 39→40 three cycles after the first sample, then +1 every 3 cycles; userY stays 35.
- At userX = 40, keycode = 8'h07, tile_data[TR] = 2 in S_CHK → userX stays 40, no commit; repeats indefinitely.
- Danger_addr[3] = 21 (tile of spawn corner TL), valid, invuln = 0:
  - → collide pulses once and lives_left 3→2;
  - next cycle position = (39, 35) and invuln = 1 for 64 cycles;
  - no second hit while danger persists during that window.
- Three lethal hits, each after invuln expires → lives_left 0, game_over = 1 sticky; keycode 8'h04 has no effect; Reset restores lives_left = 3.
- keycode 8'h19 held 10 cycles → bomb_drop exactly 1 pulse; release then press again → second pulse; enable = 0 during press → no pulse.
- Corner cases:
  - keycode 8'h04 at userX = X_MIN → rejected in S_IDLE, no S_WAIT entry.
  - Async Reset asserted in S_WAIT → immediate spawn values and S_IDLE, no stale commit afterwards.
